// File: rtl/drive_state_ctrl.sv
// drive_state_ctrl
//   Vehicle drive-state controller: power-up hold, start/stall sequencing,
//   gear-fault detection, registered motion/turn commands and a mileage
//   odometer that counts MOVING time in MILE_TICK_CYCLES units.
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   power_on, power_off     : debounced power buttons (level)
//   throttle, clutch, brake : driver controls (level)
//   reverse                 : 1 selects reverse gear
//   left, right             : turn switches (level)
//   state                   : 0=OFF 1=NOT_STARTING 2=STARTING 3=MOVING
//   move_fwd, move_back     : motion commands (never both high)
//   turn_left, turn_right   : turn commands
//   mileage                 : distance units since last power-up (wraps)
module drive_state_ctrl #(
  parameter int unsigned PWR_HOLD_CYCLES  = 100000000,
  parameter int unsigned MILE_TICK_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_on,
  input  logic        power_off,
  input  logic        throttle,
  input  logic        clutch,
  input  logic        brake,
  input  logic        reverse,
  input  logic        left,
  input  logic        right,
  output logic [1:0]  state,
  output logic        move_fwd,
  output logic        move_back,
  output logic        turn_left,
  output logic        turn_right,
  output logic [23:0] mileage
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_NST  = 2'd1;
  localparam logic [1:0] S_STRT = 2'd2;
  localparam logic [1:0] S_MOV  = 2'd3;

  localparam int HW = (PWR_HOLD_CYCLES  > 1) ? $clog2(PWR_HOLD_CYCLES)  : 1;
  localparam int TW = (MILE_TICK_CYCLES > 1) ? $clog2(MILE_TICK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(PWR_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(MILE_TICK_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [23:0]   mile_q, mile_d;
  logic          rev_q;
  logic          fwd_q, back_q, tl_q, tr_q;
  logic          gear_flt;
  logic          drive_d;

  // Changing gear without the clutch only matters while the engine is
  // coupled (STARTING/MOVING); the state case below applies it there.
  assign gear_flt = (reverse != rev_q) & ~clutch;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tick_d  = tick_q;
    mile_d  = mile_q;

    if (power_off) begin
      state_d = S_OFF;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (power_on) begin
            if (hold_q == HOLD_LAST) state_d = S_NST;
            else                     hold_d  = hold_q + HW'(1);
          end else begin
            hold_d = '0;
          end
        end
        S_NST: begin
          if (throttle & ~clutch)               state_d = S_OFF;   // stall
          else if (throttle & clutch & ~brake)  state_d = S_STRT;
        end
        S_STRT: begin
          if (gear_flt)                         state_d = S_OFF;
          else if (brake)                       state_d = S_NST;
          else if (throttle & ~clutch)          state_d = S_MOV;
        end
        S_MOV: begin
          if (gear_flt)                         state_d = S_OFF;
          else if (brake)                       state_d = S_NST;
          else if (~throttle | clutch)          state_d = S_STRT;
        end
        default:                                state_d = S_OFF;
      endcase
    end

    // Odometer: every cycle spent in MOVING advances the tick counter.
    if (state_q == S_MOV) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        mile_d = mile_q + 24'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    // Hold counter only lives inside OFF; leaving OFF or pressing
    // power_off restarts the power-up qualification.
    if ((state_d != S_OFF) || power_off) hold_d = '0;

    if (state_d == S_OFF) begin
      tick_d = '0;
      mile_d = '0;
    end
  end

  assign drive_d = (state_d == S_STRT) || (state_d == S_MOV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      hold_q  <= '0;
      tick_q  <= '0;
      mile_q  <= '0;
      rev_q   <= 1'b0;
      fwd_q   <= 1'b0;
      back_q  <= 1'b0;
      tl_q    <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tick_q  <= tick_d;
      mile_q  <= mile_d;
      rev_q   <= reverse;
      fwd_q   <= (state_d == S_MOV) & ~reverse;
      back_q  <= (state_d == S_MOV) &  reverse;
      tl_q    <= drive_d & left  & ~right;
      tr_q    <= drive_d & right & ~left;
    end
  end

  assign state      = state_q;
  assign move_fwd   = fwd_q;
  assign move_back  = back_q;
  assign turn_left  = tl_q;
  assign turn_right = tr_q;
  assign mileage    = mile_q;

endmodule

// File: tb/tb_drive_state_ctrl.sv
// tb_drive_state_ctrl
//   Directed scenarios plus randomized driving against a behavioural model
//   of the drive-state rules (PWR_HOLD_CYCLES=4, MILE_TICK_CYCLES=3).
module tb_drive_state_ctrl;
  localparam int P = 4;
  localparam int T = 3;

  logic clk = 1'b0;
  logic rst_n, power_on, power_off, throttle, clutch, brake, reverse, left, right;
  logic [1:0]  state;
  logic        move_fwd, move_back, turn_left, turn_right;
  logic [23:0] mileage;

  drive_state_ctrl #(.PWR_HOLD_CYCLES(P), .MILE_TICK_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .power_on(power_on), .power_off(power_off),
    .throttle(throttle), .clutch(clutch), .brake(brake), .reverse(reverse),
    .left(left), .right(right), .state(state), .move_fwd(move_fwd),
    .move_back(move_back), .turn_left(turn_left), .turn_right(turn_right),
    .mileage(mileage)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state (plain integers)
  int m_st = 0, m_hold = 0, m_tick = 0, m_mile = 0;
  bit m_rev = 0;
  int e_fwd = 0, e_back = 0, e_tl = 0, e_tr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    int ns;
    bit fault;
    if (!rst_n) begin
      m_st = 0; m_hold = 0; m_tick = 0; m_mile = 0; m_rev = 0;
      e_fwd = 0; e_back = 0; e_tl = 0; e_tr = 0;
      return;
    end
    ns = m_st;
    fault = (reverse != m_rev) && !clutch && (m_st >= 2);
    if (power_off) ns = 0;
    else if (m_st == 0) begin
      if (!power_on) m_hold = 0;
      else if (m_hold + 1 == P) ns = 1;
      else m_hold++;
    end
    else if (m_st == 1 && throttle && !clutch) ns = 0;
    else if (fault) ns = 0;
    else if (m_st >= 2 && brake) ns = 1;
    else if (m_st == 1 && throttle && clutch && !brake) ns = 2;
    else if (m_st == 2 && throttle && !clutch) ns = 3;
    else if (m_st == 3 && (!throttle || clutch)) ns = 2;

    if (m_st == 3) begin
      m_tick++;
      if (m_tick == T) begin m_tick = 0; m_mile = (m_mile + 1) % (1 << 24); end
    end
    if (ns != 0 || power_off) m_hold = 0;
    if (ns == 0) begin m_tick = 0; m_mile = 0; end

    e_fwd  = (ns == 3 && !reverse);
    e_back = (ns == 3 && reverse);
    e_tl   = (ns >= 2 && left && !right);
    e_tr   = (ns >= 2 && right && !left);
    m_st   = ns;
    m_rev  = reverse;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("state",      state,      m_st);
    chk("move_fwd",   move_fwd,   e_fwd);
    chk("move_back",  move_back,  e_back);
    chk("turn_left",  turn_left,  e_tl);
    chk("turn_right", turn_right, e_tr);
    chk("mileage",    mileage,    m_mile);
  endtask

  task automatic idle_in();
    power_on = 0; power_off = 0; throttle = 0; clutch = 0; brake = 0;
    left = 0; right = 0;
  endtask

  task automatic go_moving();
    idle_in();
    power_on = 1;
    repeat (P) step();
    power_on = 0;
    chk("pwrup", state, 1);
    throttle = 1; clutch = 1; step();
    chk("to_start", state, 2);
    clutch = 0; step();
    chk("to_move", state, 3);
  endtask

  initial begin
    rst_n = 0; reverse = 0;
    idle_in();
    throttle = 1; power_on = 1;
    repeat (2) step();
    chk("rst_state", state, 0);
    chk("rst_mile", mileage, 0);
    rst_n = 1; idle_in();

    // interrupted hold: 3 high, 1 low, 3 high never powers up
    power_on = 1; repeat (3) step();
    power_on = 0; step();
    power_on = 1; repeat (3) step();
    chk("hold_broken", state, 0);
    power_on = 0; step();
    power_on = 1; repeat (3) step();
    chk("hold_3", state, 0);
    step();
    chk("hold_4", state, 1);
    power_on = 0;

    throttle = 1; clutch = 1; step();
    chk("start", state, 2);
    clutch = 0; step();
    chk("move", state, 3);
    chk("fwd", move_fwd, 1);
    repeat (6) step();
    chk("mile2", mileage, 2);

    left = 1; step();
    chk("tl", turn_left, 1);
    right = 1; step();
    chk("tl_both", turn_left, 0);
    chk("tr_both", turn_right, 0);
    left = 0; right = 0;

    reverse = 1; clutch = 1; step();
    chk("rev_clutch", state, 2);
    clutch = 0; step();
    chk("back", move_back, 1);
    chk("back_fwd", move_fwd, 0);

    brake = 1; step();
    chk("brake", state, 1);
    brake = 0; step();
    chk("stall", state, 0);
    chk("stall_mile", mileage, 0);

    go_moving();
    reverse = 0; step();
    chk("gear_fault", state, 0);

    go_moving();
    brake = 1; step();
    chk("brake_thr", state, 1);
    idle_in();
    go_moving();
    brake = 1; power_off = 1; step();
    chk("brake_poff", state, 0);

    go_moving();
    left = 1;
    repeat (15) step();
    chk("mile5", mileage, 5);
    rst_n = 0; step();
    rst_n = 1;
    chk("rst_mov_state", state, 0);
    chk("rst_mov_mile", mileage, 0);
    chk("rst_mov_tl", turn_left, 0);
    chk("rst_mov_fwd", move_fwd, 0);

    // randomized driving
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(199) != 0);
      power_on  = ($urandom_range(9) != 0);
      power_off = ($urandom_range(49) == 0);
      throttle  = ($urandom_range(9) < 7);
      clutch    = ($urandom_range(9) < 4);
      brake     = ($urandom_range(19) == 0);
      if ($urandom_range(19) == 0) reverse = ~reverse;
      left      = $urandom_range(1);
      right     = $urandom_range(1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
